ht_cmd_mux: RTL and testbench

Multi-client front end for the hash table. It arbitrates round-robin between `CLIENT_CNT` independent command streams and issues one command per cycle into the single hash-table command port. It routes each in-order result back to the client that issued the command. `OP_INIT` is handled as a drain-and-exclusive operation, so no other command overlaps a table clear.

---
 rtl/ht_cmd_mux.sv | 182 ++++++++++++++++++
 tb/tb_ht_cmd_mux.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_cmd_mux.sv
// Round-robin command front end for the hash table. A tag FIFO records the issuing
// client of every command so in-order results can be routed back to it.
module ht_cmd_mux #(
    parameter int unsigned CLIENT_CNT    = 4,
    parameter int unsigned KEY_WIDTH     = 32,
    parameter int unsigned VALUE_WIDTH   = 16,
    parameter int unsigned RESCODE_WIDTH = 3,
    parameter int unsigned MAX_INFLIGHT  = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,

    input  logic [CLIENT_CNT-1:0]              cmd_valid_i,
    output logic [CLIENT_CNT-1:0]              cmd_ready_o,
    input  logic [CLIENT_CNT*KEY_WIDTH-1:0]    cmd_key_i,
    input  logic [CLIENT_CNT*VALUE_WIDTH-1:0]  cmd_value_i,
    input  logic [CLIENT_CNT*2-1:0]            cmd_opcode_i,

    output logic                               ht_cmd_valid_o,
    output logic [KEY_WIDTH-1:0]               ht_cmd_key_o,
    output logic [VALUE_WIDTH-1:0]             ht_cmd_value_o,
    output logic [1:0]                         ht_cmd_opcode_o,
    input  logic                               ht_cmd_ready_i,

    input  logic                               ht_res_valid_i,
    input  logic [RESCODE_WIDTH-1:0]           ht_res_rescode_i,
    input  logic [VALUE_WIDTH-1:0]             ht_res_value_i,
    output logic                               ht_res_ready_o,

    output logic [CLIENT_CNT-1:0]              res_valid_o,
    input  logic [CLIENT_CNT-1:0]              res_ready_i,
    output logic [RESCODE_WIDTH-1:0]           res_rescode_o,
    output logic [VALUE_WIDTH-1:0]             res_value_o,

    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_cnt_o,
    output logic                               err_o
);

    localparam int unsigned TagW = $clog2(CLIENT_CNT);
    localparam int unsigned PtrW = $clog2(MAX_INFLIGHT);
    localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [1:0]  OpInit = 2'd0;

    logic                   cmd_valid_q, cmd_valid_d;
    logic [KEY_WIDTH-1:0]   cmd_key_q;
    logic [VALUE_WIDTH-1:0] cmd_value_q;
    logic [1:0]             cmd_opcode_q;

    logic [TagW-1:0]        rr_q, rr_d;
    logic [PtrW:0]          wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]          rd_ptr_q, rd_ptr_d;
    logic [TagW-1:0]        tag_mem_q [MAX_INFLIGHT];
    logic                   init_pending_q, init_pending_d;
    logic                   err_q, err_d;

    int                     scan_idx;
    logic                   found;
    logic [TagW-1:0]        win;
    logic [KEY_WIDTH-1:0]   win_key;
    logic [VALUE_WIDTH-1:0] win_value;
    logic [1:0]             win_op;

    logic                   fifo_empty, fifo_full;
    logic [PtrW:0]          occupancy;
    logic                   loadable, init_ok, grant, pop;
    logic [TagW-1:0]        head;

    // First requesting client at or after the round-robin pointer.
    always_comb begin
        scan_idx  = 0;
        found     = 1'b0;
        win       = '0;
        win_key   = '0;
        win_value = '0;
        win_op    = '0;
        for (int i = 0; i < int'(CLIENT_CNT); i++) begin
            scan_idx = int'(rr_q) + i;
            if (scan_idx >= int'(CLIENT_CNT)) begin
                scan_idx = scan_idx - int'(CLIENT_CNT);
            end
            if (!found && cmd_valid_i[scan_idx]) begin
                found     = 1'b1;
                win       = TagW'(scan_idx);
                win_key   = cmd_key_i[scan_idx*KEY_WIDTH +: KEY_WIDTH];
                win_value = cmd_value_i[scan_idx*VALUE_WIDTH +: VALUE_WIDTH];
                win_op    = cmd_opcode_i[scan_idx*2 +: 2];
            end
        end
    end

    assign occupancy  = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    assign loadable = !cmd_valid_q || ht_cmd_ready_i;
    // An INIT winner blocks everyone until the pipeline is fully drained.
    assign init_ok  = (win_op != OpInit) || (fifo_empty && !cmd_valid_q);
    assign grant    = found && loadable && !fifo_full && !init_pending_q && init_ok;

    always_comb begin
        cmd_ready_o = '0;
        if (grant) begin
            cmd_ready_o[win] = 1'b1;
        end
    end

    assign head           = tag_mem_q[rd_ptr_q[PtrW-1:0]];
    assign ht_res_ready_o = fifo_empty ? 1'b1 : res_ready_i[head];
    assign pop            = ht_res_valid_i && ht_res_ready_o && !fifo_empty;

    always_comb begin
        res_valid_o = '0;
        if (ht_res_valid_i && !fifo_empty) begin
            res_valid_o[head] = 1'b1;
        end
    end

    always_comb begin
        cmd_valid_d    = cmd_valid_q;
        rr_d           = rr_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        init_pending_d = init_pending_q;
        err_d          = err_q;
        if (grant) begin
            cmd_valid_d = 1'b1;
            wr_ptr_d    = wr_ptr_q + (PtrW+1)'(1);
            rr_d        = (win == TagW'(CLIENT_CNT - 1)) ? '0 : win + TagW'(1);
            if (win_op == OpInit) begin
                init_pending_d = 1'b1;
            end
        end else if (ht_cmd_ready_i) begin
            cmd_valid_d = 1'b0;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
            // While init_pending is set the INIT is the only entry, so any pop retires it.
            init_pending_d = 1'b0;
        end
        if (ht_res_valid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_valid_q    <= 1'b0;
            rr_q           <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            init_pending_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            cmd_valid_q    <= cmd_valid_d;
            rr_q           <= rr_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            init_pending_q <= init_pending_d;
            err_q          <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant) begin
            cmd_key_q                       <= win_key;
            cmd_value_q                     <= win_value;
            cmd_opcode_q                    <= win_op;
            tag_mem_q[wr_ptr_q[PtrW-1:0]]   <= win;
        end
    end

    assign ht_cmd_valid_o  = cmd_valid_q;
    assign ht_cmd_key_o    = cmd_key_q;
    assign ht_cmd_value_o  = cmd_value_q;
    assign ht_cmd_opcode_o = cmd_opcode_q;
    assign res_rescode_o   = ht_res_rescode_i;
    assign res_value_o     = ht_res_value_i;
    assign inflight_cnt_o  = CntW'(occupancy);
    assign err_o           = err_q;

endmodule

// File: tb/tb_ht_cmd_mux.sv
// Bench for ht_cmd_mux: a queue-based model checked every cycle plus directed scenarios
// with literal expectations.
module tb_ht_cmd_mux;

    localparam int CW = 4;
    localparam int KW = 32;
    localparam int VW = 16;
    localparam int RW = 3;
    localparam int MI = 16;
    localparam logic [1:0] OP_INIT = 2'd0;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [CW-1:0]     cmd_valid_i, cmd_ready_o;
    logic [CW*KW-1:0]  cmd_key_i;
    logic [CW*VW-1:0]  cmd_value_i;
    logic [CW*2-1:0]   cmd_opcode_i;
    logic              ht_cmd_valid_o, ht_cmd_ready_i;
    logic [KW-1:0]     ht_cmd_key_o;
    logic [VW-1:0]     ht_cmd_value_o;
    logic [1:0]        ht_cmd_opcode_o;
    logic              ht_res_valid_i, ht_res_ready_o;
    logic [RW-1:0]     ht_res_rescode_i, res_rescode_o;
    logic [VW-1:0]     ht_res_value_i, res_value_o;
    logic [CW-1:0]     res_valid_o, res_ready_i;
    logic [4:0]        inflight_cnt_o;
    logic              err_o;

    ht_cmd_mux #(
        .CLIENT_CNT   (CW),
        .KEY_WIDTH    (KW),
        .VALUE_WIDTH  (VW),
        .RESCODE_WIDTH(RW),
        .MAX_INFLIGHT (MI)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_key_i       (cmd_key_i),
        .cmd_value_i     (cmd_value_i),
        .cmd_opcode_i    (cmd_opcode_i),
        .ht_cmd_valid_o  (ht_cmd_valid_o),
        .ht_cmd_key_o    (ht_cmd_key_o),
        .ht_cmd_value_o  (ht_cmd_value_o),
        .ht_cmd_opcode_o (ht_cmd_opcode_o),
        .ht_cmd_ready_i  (ht_cmd_ready_i),
        .ht_res_valid_i  (ht_res_valid_i),
        .ht_res_rescode_i(ht_res_rescode_i),
        .ht_res_value_i  (ht_res_value_i),
        .ht_res_ready_o  (ht_res_ready_o),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready_i),
        .res_rescode_o   (res_rescode_o),
        .res_value_o     (res_value_o),
        .inflight_cnt_o  (inflight_cnt_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Table stand-in: commands it accepted, answered in order when auto_tbl is set.
    typedef struct packed {
        logic [KW-1:0] key;
        logic [1:0]    op;
    } tcmd_t;
    tcmd_t tbl_q[$];
    bit    auto_tbl = 1'b0;
    int    grant_log[$];
    int    dlv_cli[$];
    logic [VW-1:0] dlv_val[$];

    always @(negedge clk) begin : recorder
        if (rst_i) begin
            tbl_q.delete();
        end else begin
            if (ht_res_valid_i && ht_res_ready_o && tbl_q.size() > 0) tbl_q.delete(0);
            if (ht_cmd_valid_o && ht_cmd_ready_i) tbl_q.push_back({ht_cmd_key_o, ht_cmd_opcode_o});
            for (int c = 0; c < CW; c++) begin
                if (cmd_ready_o[c]) grant_log.push_back(c);
                if (res_valid_o[c] && res_ready_i[c]) begin
                    dlv_cli.push_back(c);
                    dlv_val.push_back(res_value_o);
                end
            end
        end
    end

    // Model: list of in-flight (client, opcode) pairs, the pending table command and
    // the round-robin start; expectations are evaluated at each falling edge.
    int            m_rr;
    int            m_q[$];
    logic [1:0]    m_qop[$];
    bit            m_live = 1'b0;
    bit            m_init, m_err, m_cv;
    logic [KW-1:0] m_key;
    logic [VW-1:0] m_val;
    logic [1:0]    m_op;

    always @(negedge clk) begin : model
        int            w, c;
        logic [1:0]    wop;
        bit            g, e_hrr, pop;
        logic [CW-1:0] e_rdy, e_rv;
        if (rst_i) begin
            m_live = 1'b1;
            m_rr   = 0;
            m_q.delete();
            m_qop.delete();
            m_init = 1'b0;
            m_err  = 1'b0;
            m_cv   = 1'b0;
        end else if (m_live) begin
            w   = -1;
            wop = 2'd1;
            for (int k = 0; k < CW; k++) begin
                c = (m_rr + k) % CW;
                if (w < 0 && cmd_valid_i[c]) begin
                    w   = c;
                    wop = cmd_opcode_i[2*c +: 2];
                end
            end
            g = (w >= 0) && (!m_cv || ht_cmd_ready_i) && (m_q.size() < MI) && !m_init &&
                (wop != OP_INIT || (m_q.size() == 0 && !m_cv));
            e_rdy = g ? (CW'(1) << w) : '0;
            e_rv  = '0;
            e_hrr = 1'b1;
            if (m_q.size() > 0) begin
                if (ht_res_valid_i) e_rv[m_q[0]] = 1'b1;
                e_hrr = res_ready_i[m_q[0]];
            end

            chk("m_cmd_ready", cmd_ready_o, e_rdy);
            chk("m_ht_cmd_valid", ht_cmd_valid_o, m_cv);
            if (m_cv) begin
                chk("m_ht_cmd_key", ht_cmd_key_o, m_key);
                chk("m_ht_cmd_value", ht_cmd_value_o, m_val);
                chk("m_ht_cmd_opcode", ht_cmd_opcode_o, m_op);
            end
            chk("m_res_valid", res_valid_o, e_rv);
            chk("m_ht_res_ready", ht_res_ready_o, e_hrr);
            if (e_rv != 0) begin
                chk("m_res_value", res_value_o, ht_res_value_i);
                chk("m_res_rescode", res_rescode_o, ht_res_rescode_i);
            end
            chk("m_inflight", inflight_cnt_o, m_q.size());
            chk("m_err", err_o, m_err);

            pop = ht_res_valid_i && e_hrr && (m_q.size() > 0);
            if (ht_res_valid_i && m_q.size() == 0) m_err = 1'b1;
            if (pop) begin
                if (m_qop[0] == OP_INIT) m_init = 1'b0;
                m_q.delete(0);
                m_qop.delete(0);
            end
            if (g) begin
                m_cv  = 1'b1;
                m_key = cmd_key_i[KW*w +: KW];
                m_val = cmd_value_i[VW*w +: VW];
                m_op  = wop;
                m_q.push_back(w);
                m_qop.push_back(wop);
                m_rr = (w + 1) % CW;
                if (wop == OP_INIT) m_init = 1'b1;
            end else if (ht_cmd_ready_i) begin
                m_cv = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ht_res_rescode_i = (tbl_q.size() > 0) ? {1'b0, tbl_q[0].op} : '0;
        ht_res_value_i   = (tbl_q.size() > 0) ? (tbl_q[0].key[15:0] ^ 16'hA5A5) : '0;
        if (auto_tbl) ht_res_valid_i = (tbl_q.size() > 0);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 80; k++) begin
            if (inflight_cnt_o == 0 && !ht_cmd_valid_o) break;
            tick();
        end
        #3;
        chk(name, inflight_cnt_o, 0);
    endtask

    task automatic wait_grant(input string name, input logic [CW-1:0] exp);
        for (int k = 0; k < 40; k++) begin
            #3;
            if (cmd_ready_o != 0) break;
            tick();
        end
        chk(name, cmd_ready_o, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int exp_rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [VW-1:0] exp_rv[4] = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};

    initial begin
        cmd_valid_i      = '0;
        cmd_key_i        = '0;
        cmd_value_i      = '0;
        cmd_opcode_i     = 8'h55;
        ht_cmd_ready_i   = 1'b1;
        ht_res_valid_i   = 1'b0;
        ht_res_rescode_i = '0;
        ht_res_value_i   = '0;
        res_ready_i      = '1;

        tick();
        tick();
        rst_i = 1'b0;
        #3;
        chk("rst_ht_cmd_valid", ht_cmd_valid_o, 0);
        chk("rst_cmd_ready", cmd_ready_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_inflight", inflight_cnt_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_ht_res_ready", ht_res_ready_o, 1);

        // Round robin, all clients searching, table answers immediately.
        tick();
        auto_tbl    = 1'b1;
        cmd_key_i   = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        cmd_value_i = {16'h0033, 16'h0022, 16'h0011, 16'h0000};
        grant_log.delete();
        dlv_cli.delete();
        dlv_val.delete();
        cmd_valid_i = 4'b1111;
        repeat (8) tick();
        cmd_valid_i = '0;
        drain("rr_drain");
        chk("rr_grant_cnt", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("rr_grant_seq", grant_log[i], exp_rr[i]);
        chk("rr_dlv_cnt", dlv_cli.size(), 8);
        for (int i = 0; i < 4 && i < dlv_cli.size(); i++) begin
            chk("rr_dlv_client", dlv_cli[i], i);
            chk("rr_dlv_value", dlv_val[i], exp_rv[i]);
        end

        // Backpressure with client 2 loaded.
        cmd_key_i   = {32'h0, 32'hB00C_0002, 32'h0, 32'h0000_0A0A};
        cmd_valid_i = 4'b0100;
        tick();
        ht_cmd_ready_i = 1'b0;
        cmd_valid_i    = 4'b0001;
        repeat (5) begin
            #3;
            chk("bp_key_stable", ht_cmd_key_o, 32'hB00C_0002);
            chk("bp_no_grant", cmd_ready_o, 0);
            tick();
        end
        ht_cmd_ready_i = 1'b1;
        #3;
        chk("bp_issue_valid", ht_cmd_valid_o, 1);
        chk("bp_issue_key", ht_cmd_key_o, 32'hB00C_0002);
        chk("bp_next_grant", cmd_ready_o, 4'b0001);
        tick();
        cmd_valid_i = '0;
        #3;
        chk("bp_next_key", ht_cmd_key_o, 32'h0000_0A0A);
        drain("bp_drain");

        // In-flight limit with results withheld.
        auto_tbl = 1'b0;
        grant_log.delete();
        cmd_valid_i = 4'b1111;
        repeat (20) tick();
        #3;
        chk("full_grants", grant_log.size(), 16);
        chk("full_inflight", inflight_cnt_o, 16);
        chk("full_no_grant", cmd_ready_o, 0);
        tick();
        ht_res_valid_i = 1'b1;
        #3;
        chk("full_pop_no_grant", cmd_ready_o, 0);
        tick();
        ht_res_valid_i = 1'b0;
        #3;
        chk("full_one_grant", $countones(cmd_ready_o), 1);
        chk("full_after_pop", inflight_cnt_o, 15);
        tick();
        #3;
        chk("full_again", cmd_ready_o, 0);
        chk("full_grants2", grant_log.size(), 17);
        cmd_valid_i = '0;
        auto_tbl    = 1'b1;
        drain("full_drain");

        // INIT drain and exclusivity.
        auto_tbl    = 1'b0;
        cmd_valid_i = 4'b0001;
        repeat (3) tick();
        cmd_opcode_i = {2'd1, 2'd1, 2'd0, 2'd1};
        cmd_valid_i  = 4'b1010;
        repeat (3) begin
            #3;
            chk("init_blocked", cmd_ready_o, 0);
            tick();
        end
        auto_tbl = 1'b1;
        wait_grant("init_grant", 4'b0010);
        chk("init_grant_empty", inflight_cnt_o, 0);
        tick();
        cmd_valid_i = 4'b1000;
        #3;
        chk("init_pending_block", cmd_ready_o, 0);
        chk("init_alone_op", ht_cmd_opcode_o, 0);
        wait_grant("init_then_c3", 4'b1000);
        chk("init_c3_empty", inflight_cnt_o, 0);
        tick();
        cmd_valid_i  = '0;
        cmd_opcode_i = 8'h55;
        drain("init_drain");

        // Result routing with client 0 stalled.
        dlv_cli.delete();
        dlv_val.delete();
        res_ready_i = 4'b1110;
        cmd_valid_i = 4'b0001;
        tick();
        cmd_valid_i = 4'b0100;
        tick();
        cmd_valid_i = '0;
        repeat (3) tick();
        #3;
        chk("stall_ht_res_ready", ht_res_ready_o, 0);
        chk("stall_res_valid", res_valid_o, 4'b0001);
        repeat (2) tick();
        #3;
        chk("stall_hold", inflight_cnt_o, 2);
        res_ready_i = 4'b1111;
        #3;
        chk("stall_rel_c0", res_valid_o, 4'b0001);
        chk("stall_rel_ready", ht_res_ready_o, 1);
        tick();
        #3;
        chk("stall_rel_c2", res_valid_o, 4'b0100);
        drain("stall_drain");
        chk("stall_dlv_cnt", dlv_cli.size(), 2);
        if (dlv_cli.size() == 2) begin
            chk("stall_dlv_first", dlv_cli[0], 0);
            chk("stall_dlv_second", dlv_cli[1], 2);
        end

        // Protocol error, stickiness, and reset mid-operation.
        auto_tbl = 1'b0;
        tick();
        ht_res_valid_i = 1'b1;
        #3;
        chk("err_consume", ht_res_ready_o, 1);
        chk("err_no_route", res_valid_o, 0);
        tick();
        ht_res_valid_i = 1'b0;
        #3;
        chk("err_set", err_o, 1);
        repeat (3) tick();
        #3;
        chk("err_sticky", err_o, 1);
        cmd_valid_i = 4'b0011;
        repeat (2) tick();
        cmd_valid_i = '0;
        #3;
        chk("mid_inflight", inflight_cnt_o, 2);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #3;
        chk("mid_rst_err", err_o, 0);
        chk("mid_rst_inflight", inflight_cnt_o, 0);
        chk("mid_rst_cmd_valid", ht_cmd_valid_o, 0);
        tick();
        ht_res_valid_i = 1'b1;
        #3;
        chk("late_res_ready", ht_res_ready_o, 1);
        tick();
        ht_res_valid_i = 1'b0;
        #3;
        chk("late_res_err", err_o, 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
